load_store_unit: RTL and testbench

- Multi-cycle load/store unit downstream of the core datapath's execute stage.
- Consumes the ALU result as a byte address, the rs2 value as store data, and funct3 as the access type.
- Drives a request/grant/rvalid data-memory port with byte enables.
- Returns sign- or zero-extended load data, plus a done/error response, to the writeback stage.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-type encodings, FSM states
// and the access-legality check also used by the decoder.
package lsu_pkg;

   localparam int unsigned LANE_W = 32;
   localparam int unsigned BE_W   = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   // Stores only have signed encodings; loads add the unsigned byte/half forms.
   function automatic logic lsu_legal(input logic we, input logic [2:0] funct3);
      logic ok;
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      if (!we) begin
         ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store-side enables/replication/alignment check and
// load-side lane extraction with sign or zero extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]        st_funct3,
   input  logic [1:0]        st_off,
   input  logic [LANE_W-1:0] st_wdata,
   output logic [BE_W-1:0]   be_c,
   output logic [LANE_W-1:0] st_data_c,
   output logic              misaligned_c,
   input  logic [2:0]        ld_funct3,
   input  logic [1:0]        ld_off,
   input  logic [LANE_W-1:0] ld_rdata,
   output logic [LANE_W-1:0] ld_data_c
);

   logic [LANE_W-1:0] shifted;

   // Enables cover load encodings too so loads drive the accessed lanes.
   always_comb begin
      be_c         = '0;
      st_data_c    = st_wdata;
      misaligned_c = 1'b0;
      case (st_funct3)
         F3_B, F3_BU: begin
            be_c      = 4'b0001 << st_off;
            st_data_c = {4{st_wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            be_c         = 4'b0011 << {st_off[1], 1'b0};
            st_data_c    = {2{st_wdata[15:0]}};
            misaligned_c = st_off[0];
         end
         F3_W: begin
            be_c         = 4'b1111;
            misaligned_c = (st_off != 2'b00);
         end
         default: begin
            be_c = '0;
         end
      endcase
   end

   // Aligned halves have off[0] = 0, so one byte-granular shift serves both sizes.
   assign shifted = ld_rdata >> {ld_off, 3'b000};

   always_comb begin
      ld_data_c = '0;
      case (ld_funct3)
         F3_B:    ld_data_c = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   ld_data_c = {24'h0, shifted[7:0]};
         F3_H:    ld_data_c = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   ld_data_c = {16'h0, shifted[15:0]};
         F3_W:    ld_data_c = ld_rdata;
         default: ld_data_c = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one access from execute, runs it on the
// req/gnt/rvalid data-memory port and returns a registered response to writeback.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_W     = LANE_W,
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned RF_ADDRESS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [RF_ADDRESS-1:0] req_rd,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [BE_W-1:0]       mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_W-1:0]     resp_data,
   output logic [RF_ADDRESS-1:0] resp_rd,
   output logic                  resp_err,
   output logic                  busy
);

   lsu_state_t            state, state_n;
   logic                  we_q, we_n;
   logic [2:0]            f3_q, f3_n;
   logic [1:0]            off_q, off_n;
   logic [RF_ADDRESS-1:0] rd_q, rd_n;

   logic                  req_ready_n, busy_n;
   logic                  mem_req_n, mem_we_n;
   logic [DM_ADDRESS-1:0] mem_addr_n;
   logic [BE_W-1:0]       mem_be_n;
   logic [DATA_W-1:0]     mem_wdata_n;
   logic                  resp_valid_n, resp_err_n;
   logic [DATA_W-1:0]     resp_data_n;
   logic [RF_ADDRESS-1:0] resp_rd_n;

   logic [BE_W-1:0]       be_c;
   logic [LANE_W-1:0]     st_data_c;
   logic [LANE_W-1:0]     ld_data_c;
   logic                  misaligned_c;
   logic                  legal_c;
   logic                  unused_addr_c;

   // Bits above the data-memory window are dropped without a range error.
   assign unused_addr_c = ^req_addr[DATA_W-1:DM_ADDRESS];

   lsu_lane_align u_align (
      .st_funct3    (req_funct3),
      .st_off       (req_addr[1:0]),
      .st_wdata     (req_wdata[LANE_W-1:0]),
      .be_c         (be_c),
      .st_data_c    (st_data_c),
      .misaligned_c (misaligned_c),
      .ld_funct3    (f3_q),
      .ld_off       (off_q),
      .ld_rdata     (mem_rdata[LANE_W-1:0]),
      .ld_data_c    (ld_data_c)
   );

   assign legal_c = lsu_legal(req_we, req_funct3) && !misaligned_c;

   // Next state and next values of every registered output.
   always_comb begin
      state_n      = state;
      we_n         = we_q;
      f3_n         = f3_q;
      off_n        = off_q;
      rd_n         = rd_q;
      mem_req_n    = mem_req;
      mem_we_n     = mem_we;
      mem_addr_n   = mem_addr;
      mem_be_n     = mem_be;
      mem_wdata_n  = mem_wdata;
      resp_valid_n = resp_valid;
      resp_data_n  = resp_data;
      resp_rd_n    = resp_rd;
      resp_err_n   = resp_err;

      case (state)
         IDLE: begin
            if (req_valid) begin
               we_n  = req_we;
               f3_n  = req_funct3;
               off_n = req_addr[1:0];
               rd_n  = req_rd;
               if (!legal_c) begin
                  state_n      = RESP;
                  resp_valid_n = 1'b1;
                  resp_err_n   = 1'b1;
                  resp_data_n  = '0;
                  resp_rd_n    = req_rd;
               end else begin
                  state_n     = REQ;
                  mem_req_n   = 1'b1;
                  mem_we_n    = req_we;
                  mem_addr_n  = {req_addr[DM_ADDRESS-1:2], 2'b00};
                  mem_be_n    = be_c;
                  mem_wdata_n = req_we ? DATA_W'(st_data_c) : '0;
               end
            end
         end
         REQ: begin
            if (mem_gnt) begin
               mem_req_n   = 1'b0;
               mem_we_n    = 1'b0;
               mem_addr_n  = '0;
               mem_be_n    = '0;
               mem_wdata_n = '0;
               if (we_q) begin
                  state_n      = RESP;
                  resp_valid_n = 1'b1;
                  resp_err_n   = 1'b0;
                  resp_data_n  = '0;
                  resp_rd_n    = '0;
               end else begin
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_n      = RESP;
               resp_valid_n = 1'b1;
               resp_err_n   = 1'b0;
               resp_data_n  = DATA_W'(ld_data_c);
               resp_rd_n    = rd_q;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_n      = IDLE;
               resp_valid_n = 1'b0;
               resp_err_n   = 1'b0;
               resp_data_n  = '0;
               resp_rd_n    = '0;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      req_ready_n = (state_n == IDLE);
      busy_n      = (state_n != IDLE);
   end

   // State, request latch and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
         rd_q       <= '0;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_n;
         we_q       <= we_n;
         f3_q       <= f3_n;
         off_q      <= off_n;
         rd_q       <= rd_n;
         req_ready  <= req_ready_n;
         busy       <= busy_n;
         mem_req    <= mem_req_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_be     <= mem_be_n;
         mem_wdata  <= mem_wdata_n;
         resp_valid <= resp_valid_n;
         resp_data  <= resp_data_n;
         resp_rd    <= resp_rd_n;
         resp_err   <= resp_err_n;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses are queued at issue
// and popped when resp_valid appears; memory-side values are captured at grant.
module tb_load_store_unit;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        err;
   } exp_t;

   logic        clk, reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req, mem_we;
   logic [8:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err, busy;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   logic [8:0]  g_addr;
   logic [3:0]  g_be;
   logic [31:0] g_wdata;
   logic        g_we;
   int          grant_cnt = 0;
   int          instab = 0;
   logic        pend = 1'b0;
   logic [8:0]  pend_addr;
   logic [3:0]  pend_be;

   load_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd     (req_rd),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory-side monitor: grabs the accepted request and flags drift while waiting.
   always @(posedge clk) begin
      if (mem_req && pend && (mem_addr != pend_addr || mem_be != pend_be)) instab++;
      if (mem_req && mem_gnt) begin
         g_addr  = mem_addr;
         g_be    = mem_be;
         g_wdata = mem_wdata;
         g_we    = mem_we;
         grant_cnt++;
      end
      pend      = mem_req && !mem_gnt;
      pend_addr = mem_addr;
      pend_be   = mem_be;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] data, input logic [4:0] rd, input logic err);
      exp_t e;
      e.data = data;
      e.rd   = rd;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   // Presents one access; returns in cycle 1 (one edge after acceptance).
   task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_rd     = rd;
      tick();
      req_valid  = 1'b0;
   endtask

   // Waits (bounded) for resp_valid, checks latency and the scoreboard entry.
   task automatic wait_resp(input string tag, input int start, input int exp_lat);
      int   lat;
      exp_t e;
      lat = start;
      while (!resp_valid && lat < 60) begin
         tick();
         lat++;
      end
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_data"}, resp_data, e.data);
         chk({tag, "_rd"}, 32'(resp_rd), 32'(e.rd));
         chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
      end
   endtask

   initial begin
      int g0;
      logic [31:0] held;

      reset      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;
      req_rd     = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      resp_ready = 1'b1;
      tick();
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      reset = 1'b1;
      tick();

      // LB from the top lane, immediate gnt/rvalid
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h80FF_1234;
      push_exp(32'hFFFF_FF80, 5'd5, 1'b0);
      issue("lb", 1'b0, 3'b000, 32'h0000_0003, 32'h0, 5'd5);
      wait_resp("lb", 1, 3);
      chk("lb_be", 32'(g_be), 32'h8);
      chk("lb_addr", 32'(g_addr), 32'h000);
      chk("lb_we", 32'(g_we), 32'd0);
      tick();
      chk("lb_idle", 32'(req_ready), 32'd1);

      // SH to the upper half
      push_exp(32'h0, 5'd0, 1'b0);
      issue("sh", 1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 5'd7);
      wait_resp("sh", 1, 2);
      chk("sh_be", 32'(g_be), 32'hC);
      chk("sh_wdata", g_wdata, 32'hABCD_ABCD);
      chk("sh_addr", 32'(g_addr), 32'h004);
      chk("sh_we", 32'(g_we), 32'd1);
      tick();

      // LH sign extension from the upper lane
      mem_rdata = 32'h8001_0000;
      push_exp(32'hFFFF_8001, 5'd12, 1'b0);
      issue("lh", 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd12);
      wait_resp("lh", 1, 3);
      chk("lh_addr", 32'(g_addr), 32'h100);
      tick();

      // Misaligned LW and illegal load funct3: errors, no memory traffic
      g0 = grant_cnt;
      push_exp(32'h0, 5'd9, 1'b1);
      issue("lw_mis", 1'b0, 3'b010, 32'h0000_0002, 32'h0, 5'd9);
      chk("lw_mis_noreq", 32'(mem_req), 32'd0);
      wait_resp("lw_mis", 1, 1);
      tick();
      push_exp(32'h0, 5'd10, 1'b1);
      issue("f3_011", 1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd10);
      wait_resp("f3_011", 1, 1);
      tick();
      chk("err_no_grant", 32'(grant_cnt - g0), 32'd0);

      // LHU with gnt delayed 3 cycles and rvalid delayed 2 cycles
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hBEEF_0000;
      instab     = 0;
      push_exp(32'h0000_BEEF, 5'd11, 1'b0);
      issue("lhu", 1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd11);
      for (int i = 1; i <= 3; i++) begin
         chk("lhu_req_held", 32'(mem_req), 32'd1);
         chk("lhu_addr_held", 32'(mem_addr), 32'h000);
         if (i < 3) tick();
      end
      tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("lhu_wait_noreq", 32'(mem_req), 32'd0);
      tick();
      tick();
      chk("lhu_no_early_resp", 32'(resp_valid), 32'd0);
      mem_rvalid = 1'b1;
      wait_resp("lhu", 7, 8);
      mem_rvalid = 1'b0;
      chk("lhu_stable", 32'(instab), 32'd0);
      chk("lhu_be", 32'(g_be), 32'hC);
      tick();

      // Response back-pressure on a store
      mem_gnt    = 1'b1;
      resp_ready = 1'b0;
      push_exp(32'h0, 5'd0, 1'b0);
      issue("bp", 1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 5'd3);
      tick();
      held = resp_data;
      for (int i = 0; i < 4; i++) begin
         chk("bp_valid_held", 32'(resp_valid), 32'd1);
         chk("bp_data_held", resp_data, held);
         chk("bp_not_ready", 32'(req_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
         tick();
      end
      resp_ready = 1'b1;
      wait_resp("bp", 6, 6);
      chk("bp_wdata", g_wdata, 32'hDEAD_BEEF);
      chk("bp_be", 32'(g_be), 32'hF);
      tick();
      chk("bp_idle_ready", 32'(req_ready), 32'd1);
      chk("bp_idle_busy", 32'(busy), 32'd0);
      chk("bp_idle_valid", 32'(resp_valid), 32'd0);

      // Reset while waiting for load data; a late rvalid must be ignored
      mem_rvalid = 1'b0;
      issue("rst_ld", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd4);
      tick();
      chk("rstw_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("rstw_busy_clr", 32'(busy), 32'd0);
      chk("rstw_ready", 32'(req_ready), 32'd1);
      chk("rstw_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      reset      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_2222;
      tick();
      mem_rvalid = 1'b0;
      chk("rstw_late_rvalid", 32'(resp_valid), 32'd0);
      tick();
      chk("rstw_late_rvalid2", 32'(resp_valid), 32'd0);

      // SW after reset; upper address bits are dropped
      push_exp(32'h0, 5'd0, 1'b0);
      issue("sw", 1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0BAD_F00D, 5'd6);
      wait_resp("sw", 1, 2);
      chk("sw_addr", 32'(g_addr), 32'h1FC);
      chk("sw_be", 32'(g_be), 32'hF);
      chk("sw_wdata", g_wdata, 32'h0BAD_F00D);
      tick();

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
